// File: rtl/skid_buffer_pkg.sv
// Shared types and constants for the skid buffer: the FSM state encoding
// and the width of the optional OUT-transfer counter.
package skid_buffer_pkg;

    // EMPTY: nothing held; BUSY: main register holds a beat;
    // FULL: main and skid registers both hold beats.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam int BEAT_CNT_W = 16;

endpackage : skid_buffer_pkg

// File: rtl/skid_buffer_beat_cnt.sv
// Free-running counter of downstream transfers, wrapping at 2^BEAT_CNT_W.
// Compiled only when SKID_BUFFER_BEAT_CNT_EN is defined, which is also the
// only build in which skid_buffer instantiates it.
`ifdef SKID_BUFFER_BEAT_CNT_EN
module skid_buffer_beat_cnt
    import skid_buffer_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inc,
    output logic [BEAT_CNT_W-1:0] count
);

    logic [BEAT_CNT_W-1:0] cnt_d;
    logic [BEAT_CNT_W-1:0] cnt_q;

    // Next count: step by one per transfer; natural overflow gives the wrap.
    always_comb begin
        cnt_d = cnt_q;
        if (inc) begin
            cnt_d = cnt_q + BEAT_CNT_W'(1);
        end
    end

    // Count register, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;

endmodule : skid_buffer_beat_cnt
`endif

// File: rtl/skid_buffer.sv
// Two-entry skid buffer that cuts every combinational path between the
// upstream and downstream handshakes: m_ready, s_valid and s_data all come
// straight from flops.
//
// Handshake: a beat moves across an interface on a rising clk edge where
// valid and ready are both high; valid never waits on ready, the payload
// stays stable while valid is high and ready is low, and the inputs
// m_valid/m_data are ignored whenever m_ready is low.
//
// Optional feature: define SKID_BUFFER_BEAT_CNT_EN to add the 16-bit
// beat_cnt output that counts downstream transfers.
module skid_buffer
    import skid_buffer_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m_valid,
    input  logic [WIDTH-1:0]      m_data,
    output logic                  m_ready,
    output logic                  s_valid,
    output logic [WIDTH-1:0]      s_data,
    input  logic                  s_ready
`ifdef SKID_BUFFER_BEAT_CNT_EN
    ,
    output logic [BEAT_CNT_W-1:0] beat_cnt
`endif
);

    state_t           state_d,   state_q;
    logic [WIDTH-1:0] main_d,    main_q;
    logic [WIDTH-1:0] skid_d,    skid_q;
    logic             s_valid_d, s_valid_q;
    logic             m_ready_d, m_ready_q;

    logic in_fire;
    logic out_fire;

    assign in_fire  = m_valid & m_ready_q;
    assign out_fire = s_valid_q & s_ready;

    // Next-state and datapath: main feeds the output, skid catches the one
    // beat that arrives while the output is stalled.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        unique case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    main_d  = m_data;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (in_fire && out_fire) begin
                    main_d = m_data;
                end else if (in_fire) begin
                    skid_d  = m_data;
                    state_d = FULL;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                // m_ready is low here, so only the drain can happen.
                if (out_fire) begin
                    main_d  = skid_q;
                    state_d = BUSY;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
        // Both flags look at the next state so they line up with the data.
        s_valid_d = (state_d != EMPTY);
        m_ready_d = (state_d != FULL);
    end

    // State and registered outputs; reset discards held beats at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= EMPTY;
            main_q    <= '0;
            skid_q    <= '0;
            s_valid_q <= 1'b0;
            m_ready_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            main_q    <= main_d;
            skid_q    <= skid_d;
            s_valid_q <= s_valid_d;
            m_ready_q <= m_ready_d;
        end
    end

    assign m_ready = m_ready_q;
    assign s_valid = s_valid_q;
    assign s_data  = main_q;

`ifdef SKID_BUFFER_BEAT_CNT_EN
    skid_buffer_beat_cnt u_beat_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (out_fire),
        .count (beat_cnt)
    );
`endif

endmodule : skid_buffer

// File: tb/tb_skid_buffer.sv
// Self-checking bench for skid_buffer: directed reset, streaming, stall and
// reset-in-FULL sequences plus a random-backpressure soak; an input monitor
// pushes accepted beats into exp_q and an output monitor pops and compares.
module tb_skid_buffer;
    import skid_buffer_pkg::*;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         m_valid;
    logic [W-1:0] m_data;
    logic         m_ready;
    logic         s_valid;
    logic [W-1:0] s_data;
    logic         s_ready;
`ifdef SKID_BUFFER_BEAT_CNT_EN
    logic [BEAT_CNT_W-1:0] beat_cnt;
`endif

    skid_buffer #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .m_valid (m_valid),
        .m_data  (m_data),
        .m_ready (m_ready),
        .s_valid (s_valid),
        .s_data  (s_data),
        .s_ready (s_ready)
`ifdef SKID_BUFFER_BEAT_CNT_EN
        ,
        .beat_cnt(beat_cnt)
`endif
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int in_cnt   = 0;
    int out_cnt  = 0;
    int sent     = 0;
    int last_out_edge = 0;
    bit stall_prev = 0;
    logic [W-1:0] stall_data = '0;
    bit rand_sready = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send_beat(input logic [W-1:0] d);
        int waited;
        waited  = 0;
        m_valid = 1'b1;
        m_data  = d;
        @(negedge clk);
        while (!m_ready && waited < 1000) begin
            waited++;
            @(negedge clk);
        end
        if (!m_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: m_ready stayed 0 for beat 0x%0h", d);
        end
        @(posedge clk);
        #1;
        m_valid = 1'b0;
        sent++;
    endtask

    task automatic idle(input int n);
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #1;
        end
    endtask

    // Random backpressure, re-rolled just after each edge when enabled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_sready) s_ready = 1'($urandom_range(0, 1));
        end
    end

    // ---------------- monitors (sample at falling edge) ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_prev = 0;
            end else begin
                if (m_valid && m_ready) begin
                    exp_q.push_back(m_data);
                    in_cnt++;
                end
                if (s_valid && s_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL out_unexpected: got 0x%0h expected no beat", s_data);
                    end else begin
                        check("out_data", 32'(s_data), 32'(exp_q.pop_front()));
                    end
                    out_cnt++;
                    last_out_edge = cyc + 1;
                end
                if (s_valid && !s_ready) begin
                    if (stall_prev) check("stall_hold", 32'(s_data), 32'(stall_data));
                    stall_prev = 1;
                    stall_data = s_data;
                end else begin
                    stall_prev = 0;
                end
            end
        end
    end

    // Overall time limit.
    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequences ----------------
    initial begin
        int c0;
        int out0;
        int t;
        rst     = 1'b1;
        m_valid = 1'b0;
        m_data  = '0;
        s_ready = 1'b0;

        // Reset values and release.
        repeat (2) @(posedge clk);
        #1;
        check("rst_s_valid", 32'(s_valid), 0);
        check("rst_m_ready", 32'(m_ready), 0);
        check("rst_s_data", 32'(s_data), 0);
        #2 rst = 1'b0;
        #1 check("release_m_ready_pre_edge", 32'(m_ready), 0);
        @(posedge clk);
        #1;
        check("release_m_ready_post_edge", 32'(m_ready), 1);
        check("release_s_valid", 32'(s_valid), 0);

        // Streaming 0x01..0x10 with s_ready high.
        s_ready = 1'b1;
        c0   = cyc;
        out0 = out_cnt;
        for (int i = 1; i <= 16; i++) send_beat(W'(i));
        check("stream_latency_valid", 32'(s_valid), 1);
        check("stream_latency_data", 32'(s_data), 32'h10);
        idle(1);
        check("stream_last_out_edge", 32'(last_out_edge), 32'(c0 + 17));
        check("stream_out_count", 32'(out_cnt - out0), 16);
        check("stream_drained", 32'(s_valid), 0);

        // Stall into FULL, then drain.
        s_ready = 1'b0;
        send_beat(8'hA1);
        send_beat(8'hA2);
        check("full_state", 32'(dut.state_q), 32'(FULL));
        check("full_m_ready", 32'(m_ready), 0);
        check("full_s_data", 32'(s_data), 32'hA1);
        idle(3);
        check("full_hold_data", 32'(s_data), 32'hA1);
        check("full_hold_m_ready", 32'(m_ready), 0);
        s_ready = 1'b1;
        idle(1);
        check("drain_m_ready", 32'(m_ready), 1);
        check("drain_s_data", 32'(s_data), 32'hA2);
        check("drain_state", 32'(dut.state_q), 32'(BUSY));
        idle(1);
        check("drain_done_valid", 32'(s_valid), 0);

        // Random backpressure over 1000 beats.
        rand_sready = 1;
        for (int i = 0; i < 1000; i++) begin
            send_beat(W'(i) ^ 8'h5A);
            idle($urandom_range(0, 2));
        end
        rand_sready = 0;
        idle(1);
        s_ready = 1'b1;
        t = 0;
        while (exp_q.size() != 0 && t < 100) begin
            idle(1);
            t++;
        end
        check("random_drain_empty", 32'(exp_q.size()), 0);
        check("accepted_equals_sent", 32'(in_cnt), 32'(sent));
        check("out_equals_in", 32'(out_cnt), 32'(in_cnt));

        // Reset while FULL discards both beats.
        s_ready = 1'b0;
        send_beat(8'hB1);
        send_beat(8'hB2);
        check("rstfull_state", 32'(dut.state_q), 32'(FULL));
        #2 rst = 1'b1;
        exp_q.delete();
        #1;
        check("rstfull_s_valid_async", 32'(s_valid), 0);
        check("rstfull_m_ready_async", 32'(m_ready), 0);
        s_ready = 1'b1;
        idle(2);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        check("rstfull_m_ready_after", 32'(m_ready), 1);
        for (int i = 0; i < 5; i++) begin
            check("rstfull_no_output", 32'(s_valid), 0);
            idle(1);
        end

`ifdef SKID_BUFFER_BEAT_CNT_EN
        // 65537 OUT transfers wrap the counter to 1.
        check("beat_cnt_reset", 32'(beat_cnt), 0);
        for (int i = 0; i < 65537; i++) send_beat(W'(i));
        idle(1);
        check("beat_cnt_wrap", 32'(beat_cnt), 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_skid_buffer
